ram_burst_ctrl: RTL and testbench
=================================

Name: ram_burst_ctrl

Overview:
- Parametrised single-port synchronous RAM with a built-in burst engine.
- One `start` command moves `len` consecutive words to or from the array, beginning at `base_addr`. The address auto-increments and wraps.
- Write beats use a valid/ready handshake. Read data streams out at one word per cycle with fixed latency.
- Successor to the team's fixed 1024x8 RAM. Sits between a bus-side DMA/sequencer and local storage.

Parameters:
- DATA_W, 8, word width in bits.
- ADDR_W, 10, address width. Array depth is 2**ADDR_W words.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous reset, active-high.
- cs  input  1  chip select. Must be high for `start` to be accepted and for a burst to continue.
- start  input  1  burst request, sampled in IDLE only.
- rw  input  1  burst direction: 1 = write, 0 = read. Sampled with `start`.
- base_addr  input  ADDR_W  first word address. Sampled with `start`.
- len  input  ADDR_W+1  number of words, 1..2**(ADDR_W+1)-1.
- wr_data  input  DATA_W  write beat data.
- wr_valid  input  1  write beat valid.
- wr_ready  output  1  engine accepts a write beat this cycle.
- rd_data  output  DATA_W  read data.
- rd_valid  output  1  `rd_data` is valid.
- busy  output  1  burst in progress.
- done  output  1  one-cycle pulse when a burst completes normally.

Behaviour:
- Reset: async assert forces state IDLE and clears `wr_ready`, `rd_valid`, `busy` and `done`. `rd_data` resets to 0. The internal address and count registers are cleared. Array contents are not cleared.
- Reset mid-burst: the burst is dropped with no `done`. Words already written are retained.
- States: IDLE, WRITE, READ, and FLUSH (the last read-pipeline cycle).
- IDLE:
  - `start && cs && len != 0` at edge T: latch `addr = base_addr` and `remaining = len`.
  - Go to WRITE if `rw = 1`, else READ.
  - `busy = 1` from T+1.
  - `start` with `len == 0`, or with `cs` low, is ignored: no state change, no `done`.
- `start` while `busy` is ignored.
- WRITE:
  - `wr_ready = 1` (registered) throughout the state.
  - Each edge with `wr_valid && wr_ready && cs`:
    - `mem[addr] <= wr_data`;
    - `addr <= addr + 1` modulo 2**ADDR_W;
    - `remaining <= remaining - 1`.
  - On the beat where `remaining == 1`: go to IDLE, `done = 1` and `busy = 0` the next cycle, `wr_ready` low the next cycle.
  - Idle cycles (`wr_valid` low) hold all state.
- READ:
  - One array read per cycle, no backpressure.
  - `rd_data = mem[addr]` and `rd_valid = 1` one cycle after the address is issued.
  - Start sampled at T: `rd_valid` is high for cycles T+2 .. T+1+len, contiguous.
  - After the last address is issued, go to FLUSH. FLUSH presents the final word with `done = 1`, then returns to IDLE.
  - `busy` is high T+1 .. T+len and low in the `done` cycle.
- Wrap: address 2**ADDR_W-1 increments to 0.
- Long bursts: `len > 2**ADDR_W` is legal. Addresses revisit; later writes overwrite earlier ones.
- Abort: `cs` low at any edge while `busy` goes to IDLE next cycle.
  - No write occurs on that edge.
  - `rd_valid` drops, `wr_ready` drops, no `done`.
- Read-during-write: not possible, since the engine is single-direction per burst.
- `rd_data` holds its last value when `rd_valid` is low.

Optional Feature:
- Macro: RAM_PARITY_EN.
- Defined:
  - Array width becomes DATA_W+1, storing even parity of each written word.
  - Extra input `par_inj` (1 bit): when high during a write beat, the stored parity bit is inverted.
  - Extra output `par_err` (1 bit): registered, asserted with `rd_valid` when the recomputed parity of the read word mismatches the stored bit. Reset value 0.
- Not defined: array is DATA_W wide, and `par_inj`/`par_err` do not exist.
- Core timing is identical in both builds.

Test Plan:
- Reset, then write burst: base=0x3FE, len=4, data 0x11,0x22,0x33,0x44, `wr_valid` held high.
  - Writes land at 0x3FE, 0x3FF, 0x000, 0x001.
  - `done` pulses once, one cycle after the 4th beat. `busy` is low in that cycle.
- Read burst: base=0x3FE, len=4.
  - `rd_valid` high for exactly 4 contiguous cycles starting T+2, `rd_data` = 0x11,0x22,0x33,0x44.
  - `done` coincides with 0x44.
- Write burst len=3 with `wr_valid` toggled 1,0,0,1,1, data 0xA0,x,x,0xA1,0xA2.
  - Exactly 3 writes at base..base+2.
  - `wr_ready` stays high until the last beat.
- Start with `len=0`, then start while `busy`: no state change, no `done`, and the in-flight burst completes unaffected.
- Abort and reset:
  - Read burst len=8, drop `cs` after the 3rd `rd_valid`: `rd_valid` low the next cycle, no `done`, `busy` low.
  - Repeat with a write burst and assert `rst` mid-burst: all outputs return to 0 immediately, and already-written words read back intact.
- RAM_PARITY_EN build: write 0x55 with `par_inj=1` at 0x010, then read 0x010: `par_err=1` aligned with `rd_valid`. Clean words give `par_err=0`.

Source files
------------

// File: rtl/ram_burst_ctrl.sv
// Single-port synchronous RAM with a burst engine: one start command streams len words in or out.
// Define RAM_PARITY_EN to store an even-parity bit per word (adds par_inj input and par_err output).
module ram_burst_ctrl #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 10
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              cs,
   input  logic              start,
   input  logic              rw,
   input  logic [ADDR_W-1:0] base_addr,
   input  logic [ADDR_W:0]   len,
   input  logic [DATA_W-1:0] wr_data,
   input  logic              wr_valid,
`ifdef RAM_PARITY_EN
   input  logic              par_inj,
   output logic              par_err,
`endif
   output logic              wr_ready,
   output logic [DATA_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              done
);

`ifdef RAM_PARITY_EN
   localparam int MEM_W = DATA_W + 1;
`else
   localparam int MEM_W = DATA_W;
`endif

   localparam logic [ADDR_W-1:0] ADDR_ONE = 1;
   localparam logic [ADDR_W:0]   REM_ONE  = 1;

   typedef enum logic [1:0] {IDLE, WRITE, READ, FLUSH} state_t;

   state_t            state_reg;
   logic [ADDR_W-1:0] addr_reg;
   logic [ADDR_W:0]   remaining_reg;
   logic [MEM_W-1:0]  mem [0:(1<<ADDR_W)-1];
   logic [MEM_W-1:0]  wr_word;
   logic              wr_beat;

   // wr_ready is only ever high in WRITE, so it alone qualifies the state.
   assign wr_beat = wr_ready && wr_valid && cs;

`ifdef RAM_PARITY_EN
   assign wr_word = {(^wr_data) ^ par_inj, wr_data};
`else
   assign wr_word = wr_data;
`endif

   always_ff @(posedge clk) begin
      if (wr_beat) begin
         mem[addr_reg] <= wr_word;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg     <= IDLE;
         addr_reg      <= '0;
         remaining_reg <= '0;
         wr_ready      <= 1'b0;
         rd_data       <= '0;
         rd_valid      <= 1'b0;
         busy          <= 1'b0;
         done          <= 1'b0;
`ifdef RAM_PARITY_EN
         par_err       <= 1'b0;
`endif
      end else begin
         done <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (start && cs && (|len)) begin
                  addr_reg      <= base_addr;
                  remaining_reg <= len;
                  busy          <= 1'b1;
                  if (rw) begin
                     state_reg <= WRITE;
                     wr_ready  <= 1'b1;
                  end else begin
                     state_reg <= READ;
                  end
               end
            end
            WRITE: begin
               if (!cs) begin
                  state_reg <= IDLE;
                  wr_ready  <= 1'b0;
                  busy      <= 1'b0;
               end else if (wr_valid) begin
                  addr_reg      <= addr_reg + ADDR_ONE;
                  remaining_reg <= remaining_reg - REM_ONE;
                  if (remaining_reg == REM_ONE) begin
                     state_reg <= IDLE;
                     wr_ready  <= 1'b0;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end
               end
            end
            READ: begin
               if (!cs) begin
                  state_reg <= IDLE;
                  rd_valid  <= 1'b0;
                  busy      <= 1'b0;
`ifdef RAM_PARITY_EN
                  par_err   <= 1'b0;
`endif
               end else begin
                  rd_data       <= mem[addr_reg][DATA_W-1:0];
`ifdef RAM_PARITY_EN
                  // Data bits plus stored parity XOR to 0 for a clean word.
                  par_err       <= ^mem[addr_reg];
`endif
                  rd_valid      <= 1'b1;
                  addr_reg      <= addr_reg + ADDR_ONE;
                  remaining_reg <= remaining_reg - REM_ONE;
                  if (remaining_reg == REM_ONE) begin
                     state_reg <= FLUSH;
                     busy      <= 1'b0;
                     done      <= 1'b1;
                  end
               end
            end
            FLUSH: begin
               state_reg <= IDLE;
               rd_valid  <= 1'b0;
`ifdef RAM_PARITY_EN
               par_err   <= 1'b0;
`endif
            end
            default: state_reg <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_ram_burst_ctrl.sv
// Directed bench for ram_burst_ctrl: wrap, gapped writes, ignored starts, cs abort, reset mid-burst.
module tb_ram_burst_ctrl;

   logic        clk = 1'b0;
   logic        rst, cs, start, rw, wr_valid;
   logic [9:0]  base_addr;
   logic [10:0] len;
   logic [7:0]  wr_data, rd_data;
   logic        wr_ready, rd_valid, busy, done;
`ifdef RAM_PARITY_EN
   logic        par_inj, par_err;
`endif

   int n_cmp = 0;
   int n_bad = 0;
   logic [7:0] model [0:1023];
   logic [4:0] vpat = 5'b11001;
   logic [7:0] dpat [5] = '{8'hA0, 8'h00, 8'h00, 8'hA1, 8'hA2};

   ram_burst_ctrl #(.DATA_W(8), .ADDR_W(10)) dut (
      .clk(clk), .rst(rst), .cs(cs), .start(start), .rw(rw),
      .base_addr(base_addr), .len(len), .wr_data(wr_data), .wr_valid(wr_valid),
`ifdef RAM_PARITY_EN
      .par_inj(par_inj), .par_err(par_err),
`endif
      .wr_ready(wr_ready), .rd_data(rd_data), .rd_valid(rd_valid),
      .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic start_burst(input logic dir, input logic [9:0] base, input int n);
      cs = 1'b1; start = 1'b1; rw = dir; base_addr = base; len = 11'(n);
      tick;
      start = 1'b0;
   endtask

   task automatic do_write(input logic [9:0] base, input int n, input logic [7:0] seed, input logic [7:0] step);
      $display("write burst base=%h len=%0d", base, n);
      wr_valid = 1'b1;
      wr_data  = seed;
      start_burst(1'b1, base, n);
      check("wr_ready_on", wr_ready, 1);
      check("wr_busy_on", busy, 1);
      for (int i = 0; i < n; i++) begin
         wr_data = seed + 8'(i) * step;
         tick;
         model[base + 10'(i)] = seed + 8'(i) * step;
         check("wr_done", done, (i == n-1));
         check("wr_busy", busy, (i != n-1));
         check("wr_ready", wr_ready, (i != n-1));
      end
      wr_valid = 1'b0;
      tick;
      check("wr_done_clr", done, 0);
   endtask

   task automatic read_check(input logic [9:0] base, input int n);
      $display("read burst base=%h len=%0d", base, n);
      start_burst(1'b0, base, n);
      check("rd_valid_t1", rd_valid, 0);
      check("rd_busy_t1", busy, 1);
      for (int k = 0; k < n; k++) begin
         tick;
         check("rd_valid", rd_valid, 1);
         check("rd_data", rd_data, model[base + 10'(k)]);
         check("rd_done", done, (k == n-1));
         check("rd_busy", busy, (k != n-1));
      end
      tick;
      check("rd_valid_end", rd_valid, 0);
      check("rd_done_end", done, 0);
   endtask

   initial begin
      rst = 1'b1; cs = 1'b0; start = 1'b0; rw = 1'b0; wr_valid = 1'b0;
      base_addr = '0; len = '0; wr_data = '0;
`ifdef RAM_PARITY_EN
      par_inj = 1'b0;
`endif
      tick; tick;
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_wr_ready", wr_ready, 0);
      check("rst_rd_valid", rd_valid, 0);
      check("rst_rd_data", rd_data, 0);
      rst = 1'b0;
      tick;

      // Wrapping write then read: 0x3FE,0x3FF,0x000,0x001.
      do_write(10'h3FE, 4, 8'h11, 8'h11);
      read_check(10'h3FE, 4);
      check("wrap_word0", model[0], 8'h33);

      // Gapped write over a prefilled region: only three beats land.
      do_write(10'h100, 4, 8'hE0, 8'h01);
      $display("gapped write burst base=100 len=3");
      start_burst(1'b1, 10'h100, 3);
      for (int j = 0; j < 5; j++) begin
         wr_valid = vpat[j];
         wr_data  = dpat[j];
         tick;
         check("gap_wr_ready", wr_ready, (j < 4));
         check("gap_done", done, (j == 4));
      end
      wr_valid = 1'b0;
      model[10'h100] = 8'hA0; model[10'h101] = 8'hA1; model[10'h102] = 8'hA2;
      read_check(10'h100, 4);

      // Zero-length start is ignored; start while busy is ignored.
      $display("start len=0");
      cs = 1'b1; start = 1'b1; rw = 1'b1; len = '0; base_addr = 10'h200;
      tick;
      start = 1'b0;
      check("len0_busy", busy, 0);
      check("len0_wr_ready", wr_ready, 0);
      check("len0_done", done, 0);
      $display("write burst base=200 len=2 with start while busy");
      wr_valid = 1'b1; wr_data = 8'h5C;
      start_burst(1'b1, 10'h200, 2);
      start = 1'b1; rw = 1'b0; base_addr = 10'h000; len = 11'd5;
      tick;
      check("busy_start_busy", busy, 1);
      check("busy_start_ready", wr_ready, 1);
      start = 1'b0; wr_data = 8'h5D;
      tick;
      check("busy_start_done", done, 1);
      check("busy_start_idle", busy, 0);
      wr_valid = 1'b0;
      tick;
      check("busy_start_after", busy, 0);
      model[10'h200] = 8'h5C; model[10'h201] = 8'h5D;
      read_check(10'h200, 2);

      // Read abort by dropping cs after the third valid word.
      $display("read burst base=3FE len=8 aborted by cs");
      start_burst(1'b0, 10'h3FE, 8);
      for (int k = 0; k < 3; k++) begin
         tick;
         check("abort_rd_valid", rd_valid, 1);
         check("abort_rd_data", rd_data, model[10'h3FE + 10'(k)]);
      end
      cs = 1'b0;
      tick;
      check("abort_rd_valid_lo", rd_valid, 0);
      check("abort_busy", busy, 0);
      check("abort_done", done, 0);
      tick;
      check("abort_done_after", done, 0);
      check("abort_hold_data", rd_data, 8'h33);
      cs = 1'b1;

      // Reset mid-write: outputs clear at once, earlier beats survive.
      $display("write burst base=300 len=6 interrupted by rst");
      wr_valid = 1'b1; wr_data = 8'h60;
      start_burst(1'b1, 10'h300, 6);
      for (int i = 0; i < 3; i++) begin
         wr_data = 8'h60 + 8'(i);
         tick;
         model[10'h300 + 10'(i)] = 8'h60 + 8'(i);
      end
      wr_valid = 1'b0;
      rst = 1'b1;
      #1;
      check("rst_mid_busy", busy, 0);
      check("rst_mid_wr_ready", wr_ready, 0);
      check("rst_mid_done", done, 0);
      check("rst_mid_rd_valid", rd_valid, 0);
      check("rst_mid_rd_data", rd_data, 0);
      #3;
      rst = 1'b0;
      tick;
      read_check(10'h300, 3);

`ifdef RAM_PARITY_EN
      $display("parity write 0x55 with injection at 010");
      par_inj = 1'b1; wr_valid = 1'b1; wr_data = 8'h55;
      start_burst(1'b1, 10'h010, 1);
      tick;
      par_inj = 1'b0; wr_valid = 1'b0;
      tick;
      do_write(10'h011, 1, 8'h56, 8'h00);
      $display("parity read base=010 len=2");
      start_burst(1'b0, 10'h010, 2);
      tick;
      check("par_valid0", rd_valid, 1);
      check("par_data0", rd_data, 8'h55);
      check("par_err0", par_err, 1);
      tick;
      check("par_data1", rd_data, 8'h56);
      check("par_err1", par_err, 0);
      tick;
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
